// File: rtl/mips_multicycle_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_multicycle_controller_pkg                                       |
// | Shared opcode, funct, ALUOp, ALU control and FSM state encodings.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package mips_multicycle_controller_pkg;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  localparam logic [5:0] C_FN_ADD = 6'b100000;
  localparam logic [5:0] C_FN_SUB = 6'b100010;
  localparam logic [5:0] C_FN_AND = 6'b100100;
  localparam logic [5:0] C_FN_OR  = 6'b100101;
  localparam logic [5:0] C_FN_SLT = 6'b101010;

  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_multicycle_controller_if                                        |
// | Controller <-> datapath bundle: instruction fields in, controls out.|
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface mips_multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
           regdst, alusrcb, pcsrc, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
           regdst, alusrcb, pcsrc, alucontrol
  );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_controller_alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_multicycle_controller_alu_decoder                               |
// | Maps ALUOp and the R-type funct field to the 4-bit ALU control code.|
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module mips_multicycle_controller_alu_decoder
  import mips_multicycle_controller_pkg::*;
(
  input  wire logic [1:0] aluop,
  input  wire logic [5:0] funct,
  output logic      [3:0] alucontrol
);

  always_comb begin
    alucontrol = C_ALU_ADD;
    case (aluop)
      C_ALUOP_ADD: alucontrol = C_ALU_ADD;
      C_ALUOP_SUB: alucontrol = C_ALU_SUB;
      C_ALUOP_FUNCT: begin
        case (funct)
          C_FN_ADD: alucontrol = C_ALU_ADD;
          C_FN_SUB: alucontrol = C_ALU_SUB;
          C_FN_AND: alucontrol = C_ALU_AND;
          C_FN_OR:  alucontrol = C_ALU_OR;
          C_FN_SLT: alucontrol = C_ALU_SLT;
          default:  alucontrol = C_ALU_ADD;
        endcase
      end
      default: alucontrol = C_ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_multicycle_controller                                           |
// | Moore main-decoder FSM plus ALU decoder for the multicycle datapath.|
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module mips_multicycle_controller
  import mips_multicycle_controller_pkg::*;
(
  input  wire logic                         clk,
  input  wire logic                         reset,
  mips_multicycle_controller_if.master      ctrl
);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_pcwrite;
  logic       w_branch;
  logic [1:0] w_aluop;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = S_FETCH;
    w_pcwrite     = 1'b0;
    w_branch      = 1'b0;
    w_aluop       = C_ALUOP_ADD;
    ctrl.memwrite = 1'b0;
    ctrl.irwrite  = 1'b0;
    ctrl.regwrite = 1'b0;
    ctrl.alusrca  = 1'b0;
    ctrl.iord     = 1'b0;
    ctrl.memtoreg = 1'b0;
    ctrl.regdst   = 1'b0;
    ctrl.alusrcb  = 2'b00;
    ctrl.pcsrc    = 2'b00;
    case (r_state)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        w_pcwrite    = 1'b1;
        ctrl.alusrcb = 2'b01;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded
        ctrl.alusrcb = 2'b11;
        case (ctrl.op)
          C_OP_LW, C_OP_SW: w_next_state = S_MEMADR;
          C_OP_RTYPE:       w_next_state = S_RTYPEEX;
          C_OP_BEQ:         w_next_state = S_BEQEX;
          C_OP_ADDI:        w_next_state = S_ADDIEX;
          C_OP_J:           w_next_state = S_JEX;
          default:          w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        w_next_state = (ctrl.op == C_OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.iord    = 1'b1;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        w_aluop      = C_ALUOP_FUNCT;
        w_next_state = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        w_aluop      = C_ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        w_branch     = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        w_next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JEX: begin
        ctrl.pcsrc = 2'b10;
        w_pcwrite  = 1'b1;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  assign ctrl.pcen = w_pcwrite | (w_branch & ctrl.zero);

  mips_multicycle_controller_alu_decoder u_alu_decoder (
    .aluop      (w_aluop),
    .funct      (ctrl.funct),
    .alucontrol (ctrl.alucontrol)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mips_multicycle_controller                                        |
// | Directed vectors against hand-derived per-state control words.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_mips_multicycle_controller;

  // Word layout: pcen memwrite irwrite regwrite alusrca iord memtoreg regdst
  //              | alusrcb[1:0] pcsrc[1:0] | alucontrol[3:0]
  localparam logic [15:0] C_E_FETCH    = 16'b1010_0000_0100_0010;
  localparam logic [15:0] C_E_DECODE   = 16'b0000_0000_1100_0010;
  localparam logic [15:0] C_E_MEMADR   = 16'b0000_1000_1000_0010;
  localparam logic [15:0] C_E_MEMRD    = 16'b0000_0100_0000_0010;
  localparam logic [15:0] C_E_MEMWB    = 16'b0001_0010_0000_0010;
  localparam logic [15:0] C_E_MEMWR    = 16'b0100_0100_0000_0010;
  localparam logic [15:0] C_E_RTYPEEX  = 16'b0000_1000_0000_0000;
  localparam logic [15:0] C_E_RTYPEWB  = 16'b0001_0001_0000_0010;
  localparam logic [15:0] C_E_BEQ_TAKE = 16'b1000_1000_0001_0110;
  localparam logic [15:0] C_E_BEQ_NOT  = 16'b0000_1000_0001_0110;
  localparam logic [15:0] C_E_ADDIWB   = 16'b0001_0000_0000_0010;
  localparam logic [15:0] C_E_JEX      = 16'b1000_0000_0010_0010;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  mips_multicycle_controller_if bus ();

  mips_multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] w_obs;
  assign w_obs = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                  bus.alusrca, bus.iord, bus.memtoreg, bus.regdst,
                  bus.alusrcb, bus.pcsrc, bus.alucontrol};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [15:0] exp);
    check(tag, w_obs, exp);
    tick();
  endtask

  logic [5:0]  fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [3:0]  alu_tab [5] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111};

  initial begin
    reset     = 1'b1;
    bus.op    = 6'b000000;
    bus.funct = 6'b000000;
    bus.zero  = 1'b0;
    tick();
    tick();
    check("reset_fetch", w_obs, C_E_FETCH);
    tick();
    check("reset_held", w_obs, C_E_FETCH);
    reset = 1'b0;

    // LW: 5 cycles
    bus.op = 6'b100011;
    step("lw_fetch", C_E_FETCH);
    step("lw_decode", C_E_DECODE);
    step("lw_memadr", C_E_MEMADR);
    step("lw_memrd", C_E_MEMRD);
    step("lw_memwb", C_E_MEMWB);
    check("lw_done", w_obs, C_E_FETCH);

    // SW: 4 cycles
    bus.op = 6'b101011;
    step("sw_fetch", C_E_FETCH);
    step("sw_decode", C_E_DECODE);
    step("sw_memadr", C_E_MEMADR);
    step("sw_memwr", C_E_MEMWR);
    check("sw_done", w_obs, C_E_FETCH);

    // RTYPE with each supported funct
    bus.op = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      bus.funct = fn_tab[i];
      step("rt_fetch", C_E_FETCH);
      step("rt_decode", C_E_DECODE);
      step("rt_ex", C_E_RTYPEEX | {12'd0, alu_tab[i]});
      step("rt_wb", C_E_RTYPEWB);
    end
    bus.funct = 6'b111000;
    step("rt_fetch_dflt", C_E_FETCH);
    step("rt_decode_dflt", C_E_DECODE);
    step("rt_ex_dflt", C_E_RTYPEEX | 16'h0002);
    step("rt_wb_dflt", C_E_RTYPEWB);
    bus.funct = 6'b000000;

    // BEQ taken / not taken
    bus.op   = 6'b000100;
    bus.zero = 1'b1;
    step("beq1_fetch", C_E_FETCH);
    step("beq1_decode", C_E_DECODE);
    step("beq1_ex", C_E_BEQ_TAKE);
    bus.zero = 1'b0;
    step("beq0_fetch", C_E_FETCH);
    step("beq0_decode", C_E_DECODE);
    step("beq0_ex", C_E_BEQ_NOT);

    // J
    bus.op = 6'b000010;
    step("j_fetch", C_E_FETCH);
    step("j_decode", C_E_DECODE);
    step("j_ex", C_E_JEX);

    // ADDI
    bus.op = 6'b001000;
    step("addi_fetch", C_E_FETCH);
    step("addi_decode", C_E_DECODE);
    step("addi_ex", C_E_MEMADR);
    step("addi_wb", C_E_ADDIWB);

    // Illegal opcode is dropped after DECODE
    bus.op = 6'b111111;
    step("ill_fetch", C_E_FETCH);
    step("ill_decode", C_E_DECODE);
    step("ill_back", C_E_FETCH);
    step("ill_decode2", C_E_DECODE);

    // Reset during MEMRD aborts the load
    bus.op = 6'b100011;
    step("rst_fetch", C_E_FETCH);
    step("rst_decode", C_E_DECODE);
    step("rst_memadr", C_E_MEMADR);
    check("rst_memrd", w_obs, C_E_MEMRD);
    reset = 1'b1;
    tick();
    check("rst_abort", w_obs, C_E_FETCH);
    reset = 1'b0;
    tick();
    check("rst_resume", w_obs, C_E_DECODE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Control unit for the multicycle MIPS datapath. It holds a Moore main-decoder FSM that sequences fetch, decode, execute, memory and writeback steps from the instruction opcode. It also has a combinational ALU decoder that maps ALUOp and funct to a 4-bit ALU control code. It sits beside the datapath, takes op/funct/zero from the datapath and drives all mux selects and write enables.

Parameters:
None. Opcode, funct and state encodings are fixed constants in the shared package.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high; forces the FSM to FETCH
op  in  6  instruction opcode, instr[31:26]
funct  in  6  function field, instr[5:0]
zero  in  1  ALU zero flag
pcen  out  1  PC register enable; pcen = pcwrite | (branch & zero)
memwrite  out  1  memory write enable
irwrite  out  1  instruction register write enable
regwrite  out  1  register file write enable
alusrca  out  1  ALU A select: 0 = PC, 1 = register A
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memtoreg  out  1  writeback select: 0 = ALUOut, 1 = Data register
regdst  out  1  destination select: 0 = rt, 1 = rd
alusrcb  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
alucontrol  out  4  ALU operation code

Behaviour:
- One clock (clk). Reset is synchronous and active-high. On a rising edge with reset=1, state becomes FETCH. Reset asserted in the middle of an instruction aborts it at the next edge.
- All outputs are combinational from the current state (Moore), except pcen (also uses zero) and alucontrol (also uses funct).
- In every state, any output not listed below is 0.
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- States, their outputs and their next state:
  FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00. Next: DECODE.
  DECODE: alusrcb=11, aluop=00. Next: LW/SW -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; ADDI -> ADDIEX; J -> JEX; any other op -> FETCH (the instruction is ignored).
  MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: LW -> MEMRD; SW -> MEMWR.
  MEMRD: iord=1. Next: MEMWB.
  MEMWB: memtoreg=1, regwrite=1. Next: FETCH.
  MEMWR: iord=1, memwrite=1. Next: FETCH.
  RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next: RTYPEWB.
  RTYPEWB: regdst=1, regwrite=1. Next: FETCH.
  BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next: FETCH.
  ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
  ADDIWB: regwrite=1. Next: FETCH.
  JEX: pcsrc=10, pcwrite=1. Next: FETCH.
- Unused state encodings return to FETCH on the next edge, with all outputs 0.
- Instruction latency: LW 5 cycles; SW, RTYPE, ADDI 4 cycles; BEQ, J 3 cycles.
- While reset is held, the FSM stays in FETCH, so the FETCH outputs are driven, including pcen=1.
- ALU decoder:
  aluop=00 -> alucontrol 0010 (add).
  aluop=01 -> 0110 (sub).
  aluop=10 -> decode funct: 100000 add -> 0010; 100010 sub -> 0110; 100100 and -> 0000; 100101 or -> 0001; 101010 slt -> 0111; any other funct -> 0010.
  aluop=11 -> 0010.

Decomposition:
- Package: opcode constants, funct constants, ALUOp encoding, alucontrol codes, and the FSM state enum (4-bit encoding).
- Sub-module alu_decoder, a combinational block mapping aluop+funct to alucontrol.
- The FSM and the pcen logic stay in the top module.

Test Plan:
- Reset: hold reset for 2 edges -> state FETCH; irwrite=1, pcen=1, alusrcb=01, alucontrol=0010, memwrite=0, regwrite=0.
- LW (op=100011), starting from FETCH: check outputs each cycle.
  Cycle 2: alusrcb=11.
  Cycle 3: alusrca=1, alusrcb=10.
  Cycle 4: iord=1.
  Cycle 5: regwrite=1, memtoreg=1, regdst=0.
  Cycle 6: back in FETCH.
- SW (op=101011): cycle 4 has iord=1, memwrite=1; regwrite is never asserted.
- RTYPE (op=000000), funct 100000/100010/100100/100101/101010: in RTYPEEX, alucontrol = 0010/0110/0000/0001/0111. Next cycle regdst=1, regwrite=1.
- BEQ (op=000100), in BEQEX:
  zero=1 -> pcen=1, pcsrc=01, alucontrol=0110.
  zero=0 -> pcen=0.
  J (op=000010) -> JEX with pcen=1, pcsrc=10.
- ADDI (op=001000): ADDIEX has alusrcb=10, then ADDIWB has regwrite=1, regdst=0. Illegal op=111111: DECODE -> FETCH. Reset asserted during MEMRD: FETCH at the next edge.
